// File: rtl/hms_time_sync_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hms_time_sync_ctrl_if
// Brief    : Requester handshake and timekeeper program/readback bundle.
// Revision : 1.0  initial release
// ============================================================================
interface hms_time_sync_ctrl_if;
    logic       req0;
    logic       req1;
    logic [4:0] hrs0;
    logic [4:0] hrs1;
    logic [5:0] min0;
    logic [5:0] min1;
    logic [5:0] sec0;
    logic [5:0] sec1;
    logic       ack0;
    logic       ack1;
    logic       err;
    logic [1:0] err_code;
    logic       busy;
    logic       ss;
    logic       sel;
    logic       inc;
    logic       dec;
    logic       load;
    logic [2:0] addr;
    logic [5:0] din;
    logic [3:0] t_hrs;
    logic [5:0] t_min;
    logic [5:0] t_sec;
    logic       t_am_pm_bar;

    modport master (
        input  req0, req1, hrs0, hrs1, min0, min1, sec0, sec1,
        input  t_hrs, t_min, t_sec, t_am_pm_bar,
        output ack0, ack1, err, err_code, busy,
        output ss, sel, inc, dec, load, addr, din
    );

    modport slave (
        output req0, req1, hrs0, hrs1, min0, min1, sec0, sec1,
        output t_hrs, t_min, t_sec, t_am_pm_bar,
        input  ack0, ack1, err, err_code, busy,
        input  ss, sel, inc, dec, load, addr, din
    );
endinterface
`default_nettype wire

// File: rtl/hms_time_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hms_time_sync_ctrl
// Brief    : Round-robin sequencer programming a 12-hr hms timekeeper from two
//            24-hr sources, with optional readback verification.
// Revision : 1.0  initial release
// ============================================================================
module hms_time_sync_ctrl #(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    hms_time_sync_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_VALID = 4'd1,
        S_ENTER = 4'd2,
        S_LD_H  = 4'd3,
        S_LD_M  = 4'd4,
        S_LD_S  = 4'd5,
        S_EXIT  = 4'd6,
        S_CHECK = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    localparam logic [1:0] c_ERR_RANGE = 2'b01;
    localparam logic [1:0] c_ERR_RDBK  = 2'b10;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_h;
    logic [5:0] r_m;
    logic [5:0] r_s;
    logic       r_gnt;
    logic       r_prio;
    logic       r_fail;
    logic [1:0] r_mask;
    logic [1:0] r_err_code;

    logic [1:0] w_req;
    logic       w_gnt_any;
    logic       w_gnt_sel;
    logic [1:0] w_mask_set;
    logic       w_range_bad;
    logic [3:0] w_map_h;
    logic       w_map_am;
    logic       w_s_wrap;
    logic       w_m_wrap;
    logic [3:0] w_e_h;
    logic [5:0] w_e_m;
    logic [5:0] w_e_s;
    logic       w_e_am;
    logic       w_mismatch;

    logic       w_ss;
    logic       w_load;
    logic [2:0] w_addr;
    logic [5:0] w_din;
    logic       w_ack0;
    logic       w_ack1;
    logic       w_err;

    // Masked requests keep a still-high req from being re-granted after its ack.
    assign w_req      = {bus.req1, bus.req0} & ~r_mask;
    assign w_gnt_any  = |w_req;
    assign w_gnt_sel  = (w_req == 2'b11) ? r_prio : w_req[1];
    assign w_mask_set = (r_state == S_DONE) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;

    assign w_range_bad = (r_h > 5'd23) || (r_m > 6'd59) || (r_s > 6'd59);

    // 13..23 wraps to 1..11 in 4-bit arithmetic; 12 keeps the AM flag.
    assign w_map_h  = (r_h == 5'd0)  ? 4'd12 :
                      (r_h <= 5'd12) ? r_h[3:0] : (r_h[3:0] - 4'd12);
    assign w_map_am = (r_h <= 5'd12);

    // Expected readback: loaded time advanced by the tick applied on EXIT.
    assign w_s_wrap = (r_s == 6'd59);
    assign w_m_wrap = w_s_wrap && (r_m == 6'd59);
    assign w_e_s    = w_s_wrap ? 6'd0 : (r_s + 6'd1);
    assign w_e_m    = w_m_wrap ? 6'd0 : (w_s_wrap ? (r_m + 6'd1) : r_m);
    assign w_e_h    = w_m_wrap ? ((w_map_h == 4'd12) ? 4'd1 : (w_map_h + 4'd1)) : w_map_h;
    assign w_e_am   = w_map_am ^ (w_m_wrap && (w_map_h == 4'd11));

    assign w_mismatch = (bus.t_hrs != w_e_h) || (bus.t_min != w_e_m) ||
                        (bus.t_sec != w_e_s) || (bus.t_am_pm_bar != w_e_am);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ss   = 1'b0;
        w_load = 1'b0;
        w_addr = 3'd0;
        w_din  = 6'd0;
        w_ack0 = 1'b0;
        w_ack1 = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_gnt_any) w_next = S_VALID;
            S_VALID: w_next = w_range_bad ? S_DONE : S_ENTER;
            S_ENTER: begin
                w_ss   = 1'b1;
                w_next = S_LD_H;
            end
            S_LD_H: begin
                w_load = 1'b1;
                w_addr = 3'd3;
                w_din  = {1'b0, r_h};
                w_next = S_LD_M;
            end
            S_LD_M: begin
                w_load = 1'b1;
                w_addr = 3'd2;
                w_din  = r_m;
                w_next = S_LD_S;
            end
            S_LD_S: begin
                w_load = 1'b1;
                w_addr = 3'd1;
                w_din  = r_s;
                w_next = S_EXIT;
            end
            S_EXIT: begin
                w_ss   = 1'b1;
                w_next = CHECK_EN ? S_CHECK : S_DONE;
            end
            S_CHECK: w_next = S_DONE;
            S_DONE: begin
                w_ack0 = ~r_gnt;
                w_ack1 = r_gnt;
                w_err  = r_fail;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h        <= 5'd0;
            r_m        <= 6'd0;
            r_s        <= 6'd0;
            r_gnt      <= 1'b0;
            r_prio     <= 1'b0;
            r_fail     <= 1'b0;
            r_mask     <= 2'b00;
            r_err_code <= 2'b00;
        end else begin
            r_mask <= (r_mask & {bus.req1, bus.req0}) | w_mask_set;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_gnt  <= w_gnt_sel;
                        r_fail <= 1'b0;
                        r_h    <= w_gnt_sel ? bus.hrs1 : bus.hrs0;
                        r_m    <= w_gnt_sel ? bus.min1 : bus.min0;
                        r_s    <= w_gnt_sel ? bus.sec1 : bus.sec0;
                    end
                end
                S_VALID: begin
                    if (w_range_bad) begin
                        r_fail     <= 1'b1;
                        r_err_code <= c_ERR_RANGE;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_fail     <= 1'b1;
                        r_err_code <= c_ERR_RDBK;
                    end
                end
                S_DONE: r_prio <= ~r_gnt;
                default: ;
            endcase
        end
    end

    assign bus.ss       = w_ss;
    assign bus.sel      = 1'b0;
    assign bus.inc      = 1'b0;
    assign bus.dec      = 1'b0;
    assign bus.load     = w_load;
    assign bus.addr     = w_addr;
    assign bus.din      = w_din;
    assign bus.ack0     = w_ack0;
    assign bus.ack1     = w_ack1;
    assign bus.err      = w_err;
    assign bus.err_code = r_err_code;
    assign bus.busy     = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_hms_time_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hms_time_sync_ctrl
// Brief    : Scoreboard bench with a behavioural 12-hr timekeeper model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hms_time_sync_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hms_time_sync_ctrl_if bus();

    hms_time_sync_ctrl #(.CHECK_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         who;
        bit         er;
        logic [1:0] code;
        int         lat;
        logic [5:0] dh, dm, ds;
        bit         rb;
        logic [3:0] rh;
        logic [5:0] rm, rs;
        logic       ram;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- timekeeper model (RUN/PL, load, one tick on PL->RUN)
    logic       tk_run;
    logic [3:0] tk_h;
    logic [5:0] tk_m, tk_s;
    logic       tk_am;
    logic       bad_min;

    function automatic logic [16:0] tk_tick(input logic [3:0] h, input logic [5:0] m,
                                            input logic [5:0] s, input logic am);
        logic [3:0] nh = h;
        logic [5:0] nm = m;
        logic [5:0] ns = s;
        logic       nam = am;
        if (s == 6'd59) begin
            ns = 6'd0;
            if (m == 6'd59) begin
                nm = 6'd0;
                if (h == 4'd11) nam = ~am;
                nh = (h == 4'd12) ? 4'd1 : h + 4'd1;
            end else begin
                nm = m + 6'd1;
            end
        end else begin
            ns = s + 6'd1;
        end
        return {nh, nm, ns, nam};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tk_run <= 1'b1;
            tk_h   <= 4'd12;
            tk_m   <= 6'd0;
            tk_s   <= 6'd0;
            tk_am  <= 1'b1;
        end else if (bus.ss) begin
            if (tk_run) begin
                tk_run <= 1'b0;
            end else begin
                tk_run <= 1'b1;
                {tk_h, tk_m, tk_s, tk_am} <= tk_tick(tk_h, tk_m, tk_s, tk_am);
            end
        end else if (!tk_run && bus.load) begin
            case (bus.addr)
                3'd3: begin
                    if (bus.din[4:0] == 5'd0) begin
                        tk_h <= 4'd12; tk_am <= 1'b1;
                    end else if (bus.din[4:0] <= 5'd12) begin
                        tk_h <= bus.din[3:0]; tk_am <= 1'b1;
                    end else begin
                        tk_h <= bus.din[3:0] - 4'd12; tk_am <= 1'b0;
                    end
                end
                3'd2: tk_m <= bus.din;
                3'd1: tk_s <= bus.din;
                default: ;
            endcase
        end
    end

    assign bus.t_hrs       = tk_h;
    assign bus.t_min       = tk_m ^ {5'd0, bad_min};
    assign bus.t_sec       = tk_s;
    assign bus.t_am_pm_bar = tk_am;

    // ---------------- monitor: pops the scoreboard on each ack
    int         cyc = 0, rise_cyc = 0, ss_cnt = 0, ld_cnt = 0;
    logic       prev_busy = 1'b0, prev_ack = 1'b0;
    logic [5:0] ld_h = '0, ld_m = '0, ld_s = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (rst) begin
                prev_busy = 1'b0;
                prev_ack  = 1'b0;
                ss_cnt    = 0;
                ld_cnt    = 0;
            end else begin
                if (bus.busy && !prev_busy) begin
                    rise_cyc = cyc;
                    ss_cnt   = 0;
                    ld_cnt   = 0;
                    ld_h = '0; ld_m = '0; ld_s = '0;
                end
                if (bus.ss) ss_cnt = ss_cnt + 1;
                if (bus.load) begin
                    ld_cnt = ld_cnt + 1;
                    if (bus.addr == 3'd3) ld_h = bus.din;
                    else if (bus.addr == 3'd2) ld_m = bus.din;
                    else if (bus.addr == 3'd1) ld_s = bus.din;
                end
                if (prev_ack) chk("ack_width", {30'd0, bus.ack1, bus.ack0}, 32'd0);
                if (bus.ack0 || bus.ack1) begin
                    if (sbq.size() == 0) begin
                        chk("ack_expected", sbq.size(), 32'd1);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("ack_who", {30'd0, bus.ack1, bus.ack0}, mon_e.who ? 32'd2 : 32'd1);
                        chk("err", {31'd0, bus.err}, {31'd0, mon_e.er});
                        chk("err_code", {30'd0, bus.err_code}, {30'd0, mon_e.code});
                        chk("latency", cyc - rise_cyc + 1, mon_e.lat);
                        if (mon_e.er && mon_e.code == 2'b01) begin
                            chk("ss_load_cnt", {ss_cnt[15:0], ld_cnt[15:0]}, 32'd0);
                        end else begin
                            chk("ss_load_cnt", {ss_cnt[15:0], ld_cnt[15:0]}, {16'd2, 16'd3});
                            chk("din_hrs", ld_h, mon_e.dh);
                            chk("din_min", ld_m, mon_e.dm);
                            chk("din_sec", ld_s, mon_e.ds);
                        end
                        if (mon_e.rb)
                            chk("readback", {15'd0, bus.t_hrs, bus.t_min, bus.t_sec, bus.t_am_pm_bar},
                                {15'd0, mon_e.rh, mon_e.rm, mon_e.rs, mon_e.ram});
                    end
                end
                prev_busy = bus.busy;
                prev_ack  = bus.ack0 | bus.ack1;
            end
        end
    end

    // ---------------- stimulus
    task automatic push(input bit who, input bit er, input logic [1:0] code, input int lat,
                        input logic [5:0] dh, input logic [5:0] dm, input logic [5:0] ds,
                        input bit rb, input logic [3:0] rh, input logic [5:0] rm,
                        input logic [5:0] rs, input logic ram);
        exp_t x;
        x.who = who; x.er = er; x.code = code; x.lat = lat;
        x.dh = dh; x.dm = dm; x.ds = ds;
        x.rb = rb; x.rh = rh; x.rm = rm; x.rs = rs; x.ram = ram;
        sbq.push_back(x);
    endtask

    task automatic set_data(input bit who, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s);
        if (who) begin
            bus.hrs1 = h; bus.min1 = m; bus.sec1 = s;
        end else begin
            bus.hrs0 = h; bus.min0 = m; bus.sec0 = s;
        end
    endtask

    task automatic wait_ack(input bit who);
        int n = 0;
        while (!(who ? bus.ack1 : bus.ack0) && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        chk(who ? "ack1_wait_bound" : "ack0_wait_bound", {31'd0, (n < 40)}, 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bad_min = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        set_data(1'b0, 5'd0, 6'd0, 6'd0);
        set_data(1'b1, 5'd0, 6'd0, 6'd0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {14'd0, bus.ack0, bus.ack1, bus.err, bus.busy, bus.ss, bus.sel,
            bus.inc, bus.dec, bus.load, bus.addr, bus.din}, 32'd0);
        chk("reset_err_code", {30'd0, bus.err_code}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Simultaneous pair from reset: req0 (13:45:30) first, then req1 (11:59:59).
        set_data(1'b0, 5'd13, 6'd45, 6'd30);
        set_data(1'b1, 5'd11, 6'd59, 6'd59);
        push(1'b0, 1'b0, 2'b00, 8, 6'd13, 6'd45, 6'd30, 1'b1, 4'd1, 6'd45, 6'd31, 1'b0);
        push(1'b1, 1'b0, 2'b00, 8, 6'd11, 6'd59, 6'd59, 1'b1, 4'd12, 6'd0, 6'd0, 1'b0);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_ack(1'b0); bus.req0 = 1'b0;
        @(negedge clk);
        wait_ack(1'b1); bus.req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Midnight on req0, then hold req0 after ack: must not be re-granted.
        set_data(1'b0, 5'd0, 6'd0, 6'd0);
        push(1'b0, 1'b0, 2'b00, 8, 6'd0, 6'd0, 6'd0, 1'b1, 4'd12, 6'd0, 6'd1, 1'b1);
        bus.req0 = 1'b1;
        wait_ack(1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("held_req_not_regranted", {31'd0, bus.busy}, 32'd0);
        end
        bus.req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Second pair: req1 now favoured; hrs=24 is a range error, then req0 23:59:59.
        set_data(1'b1, 5'd24, 6'd0, 6'd0);
        set_data(1'b0, 5'd23, 6'd59, 6'd59);
        push(1'b1, 1'b1, 2'b01, 2, 6'd0, 6'd0, 6'd0, 1'b0, 4'd0, 6'd0, 6'd0, 1'b0);
        push(1'b0, 1'b0, 2'b01, 8, 6'd23, 6'd59, 6'd59, 1'b1, 4'd12, 6'd0, 6'd0, 1'b1);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_ack(1'b1); bus.req1 = 1'b0;
        @(negedge clk);
        wait_ack(1'b0); bus.req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Corrupted minute readback during CHECK.
        bad_min = 1'b1;
        set_data(1'b1, 5'd12, 6'd30, 6'd0);
        push(1'b1, 1'b1, 2'b10, 8, 6'd12, 6'd30, 6'd0, 1'b0, 4'd0, 6'd0, 6'd0, 1'b0);
        bus.req1 = 1'b1;
        wait_ack(1'b1); bus.req1 = 1'b0;
        repeat (3) @(negedge clk);
        bad_min = 1'b0;
        chk("err_code_hold", {30'd0, bus.err_code}, 32'd2);

        // Reset while loading minutes: everything drops, no ack follows.
        set_data(1'b0, 5'd5, 6'd6, 6'd7);
        bus.req0 = 1'b1;
        n = 0;
        while (!(bus.load && bus.addr == 3'd2) && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("reach_ld_m_bound", {31'd0, (n < 40)}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {14'd0, bus.ack0, bus.ack1, bus.err, bus.busy, bus.ss, bus.sel,
            bus.inc, bus.dec, bus.load, bus.addr, bus.din}, 32'd0);
        chk("midrst_err_code", {30'd0, bus.err_code}, 32'd0);
        bus.req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hms_time_sync_ctrl.md
Name: hms_time_sync_ctrl

Overview:
- Sequencer/arbiter that programs the 12-hr hms timekeeper (RUN/PL/AM_PM_B/HB/MB/SB FSM, load/addr/din interface) from two independent 24-hr time sources.
- Sources: requester 0 is host/network sync; requester 1 is keypad entry. Round-robin arbitration between them.
- Drives the timekeeper's ss/sel/inc/dec/load/addr/din. Optionally reads back the timekeeper outputs to confirm the load and flags errors.

Parameters:
- CHECK_EN, 1, 1 = perform the readback check after programming; 0 = skip CHECK and go straight to DONE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0, req1  in  1 each  request; held high with data stable until the matching ack
- hrs0, hrs1  in  5 each  requested hours, 24-hr, 0..23
- min0, min1  in  6 each  requested minutes, 0..59
- sec0, sec1  in  6 each  requested seconds, 0..59
- ack0, ack1  out  1 each  one-cycle completion pulse per requester
- err  out  1  one-cycle pulse, coincident with the ack, when the request failed
- err_code  out  2  01 = range error, 10 = readback mismatch; holds its value until the next err
- busy  out  1  high in every state except IDLE
- ss, sel, inc, dec  out  1 each  to the timekeeper; sel/inc/dec are tied to 0
- load  out  1  to the timekeeper
- addr  out  3  to the timekeeper: 1 = sec, 2 = min, 3 = hrs
- din  out  6  to the timekeeper
- t_hrs  in  4  timekeeper hrs readback (1..12)
- t_min, t_sec  in  6 each  timekeeper readback
- t_am_pm_bar  in  1  timekeeper readback; 1 = AM

Behaviour:
- Reset: FSM goes to IDLE. All outputs 0, except err_code = 00. RR pointer favours req0. Both mask bits are clear.
- FSM states: IDLE, VALID, ENTER, LD_H, LD_M, LD_S, EXIT, CHECK, DONE.
- IDLE arbitration (unmasked requests only):
  - If only one requester is active, grant it.
  - If both are active, grant the one not granted last.
  - On grant, capture that requester's hrs/min/sec into registers H, M, S and go to VALID.
- VALID:
  - If H > 23, M > 59 or S > 59, set err_code = 01 and go to DONE. No timekeeper outputs are driven.
  - Otherwise go to ENTER.
- ENTER: ss = 1 for one cycle. The timekeeper moves RUN -> PL.
- LD_H: load = 1, addr = 3, din = {1'b0, H}.
- LD_M: load = 1, addr = 2, din = M.
- LD_S: load = 1, addr = 1, din = S.
- In every LD_* state, ss = 0 and sel = 0, so the timekeeper stays in PL.
- EXIT: ss = 1 for one cycle. The timekeeper returns to RUN and applies one tick on this edge.
- All timekeeper outputs are combinational decodes of the registered state. Outside ENTER, LD_* and EXIT they are 0.
- Expected value (E) in CHECK: the loaded time mapped into the timekeeper convention, then advanced by one tick.
  - Hours mapping: H = 0 gives 12 AM; H = 1..12 gives H AM (12 is flagged AM, matching the timekeeper); H = 13..23 gives H-12 PM.
  - Tick: sec wraps 59 -> 0 and carries to min; min wraps 59 -> 0 and carries to hrs; hrs wraps 12 -> 1.
  - AM/PM toggles only when hrs goes 11 -> 12 on a carry.
- CHECK (1 cycle, only when CHECK_EN = 1):
  - Compare t_hrs, t_min, t_sec and t_am_pm_bar against E.
  - Any difference sets err_code = 10.
  - Go to DONE.
- DONE:
  - Pulse the granted ack for one cycle. Pulse err in the same cycle if this request failed.
  - Set that requester's mask bit and update the RR pointer.
  - Go to IDLE.
- Mask bit: clears when the corresponding req is sampled low. This prevents re-granting a request that is still high in the cycle after its ack.
- A req that drops during service is ignored: the captured data completes and an ack is still issued.
- Latency from grant to ack:
  - Valid request, CHECK_EN = 1: 8 cycles.
  - Valid request, CHECK_EN = 0: 7 cycles.
  - Range error: 2 cycles.
- Reset mid-sequence: FSM returns to IDLE immediately and all outputs drop to 0. No ack is issued; requesters re-request.

Test Plan:
- req0 with 13:45:30 -> ss pulse; then loads hrs din=13, min din=45, sec din=30; then ss pulse. Readback 1:45:31 PM, ack0 exactly 8 cycles after grant, err=0.
- req1 with 11:59:59 -> EXIT tick gives 12:00:00 with t_am_pm_bar=0 (toggled to PM); check passes, ack1, err=0.
- req0 with 00:00:00 -> readback 12:00:01 AM; check passes.
- req0 and req1 asserted in the same cycle from reset -> req0 served first, then req1. On the next simultaneous pair, req1 is served first. Each ack is one cycle wide, and a held req is not re-granted until it has dropped.
- req1 with hrs=24 -> err=1 and err_code=01 with ack1, 2 cycles after grant. ss and load never asserted.
- Bench forces t_min wrong during CHECK -> err_code=10. Separately, rst asserted during LD_M -> all outputs 0 and no ack.
